// File: rtl/sobel_line_window.sv
// sobel_line_window: four rotating line buffers feeding one 3x3 window per cycle to the Sobel stage.
// Define SOBEL_BORDER_ZERO_EN to zero-pad columns past the right edge instead of replicating them.
module sobel_line_window #(
    parameter int IMG_WIDTH = 512,
    parameter int CNT_W     = 12
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_data_valid,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid,
    output logic        o_intr
);
    localparam int AW = $clog2(IMG_WIDTH);
    localparam logic [AW-1:0] LAST = AW'(IMG_WIDTH - 1);
    localparam logic [AW:0] W_END = (AW+1)'(IMG_WIDTH);
    localparam logic [CNT_W-1:0] THREE_LINES = CNT_W'(3 * IMG_WIDTH);

    typedef enum logic {IDLE, READ} state_t;

    state_t          r_state;
    logic [7:0]      r_mem [4][IMG_WIDTH];
    logic [AW-1:0]   r_wr_cnt;
    logic [AW-1:0]   r_rd_cnt;
    logic [1:0]      r_wr_sel;
    logic [1:0]      r_rd_sel;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [71:0]     r_data;
    logic            r_valid;
    logic            r_intr;

    logic            w_rd_en;
    logic            w_rd_last;
    logic            w_wr_last;
    logic [CNT_W-1:0] w_pix_next;
    logic [71:0]     w_win;

    assign w_rd_en    = r_state == READ;
    assign w_rd_last  = w_rd_en && r_rd_cnt == LAST;
    assign w_wr_last  = r_wr_cnt == LAST;
    assign w_pix_next = r_pix_cnt + CNT_W'(i_pixel_data_valid) - CNT_W'(w_rd_en);

    // Row 0 is the oldest buffered line; column addresses past the edge are clamped or zeroed.
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            logic [AW:0] w_addr;
            logic [1:0]  w_sel;
            assign w_addr = {1'b0, r_rd_cnt} + (AW+1)'(c);
            assign w_sel  = r_rd_sel + 2'(r);
`ifdef SOBEL_BORDER_ZERO_EN
            assign w_win[(r*3+c)*8 +: 8] = (w_addr >= W_END) ? 8'h00 : r_mem[w_sel][w_addr[AW-1:0]];
`else
            assign w_win[(r*3+c)*8 +: 8] = r_mem[w_sel][(w_addr >= W_END) ? LAST : w_addr[AW-1:0]];
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_pixel_data_valid)
            r_mem[r_wr_sel][r_wr_cnt] <= i_pixel_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_wr_sel  <= '0;
            r_rd_sel  <= '0;
            r_pix_cnt <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_intr    <= 1'b0;
        end else begin
            if (i_pixel_data_valid) begin
                r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
                r_wr_sel <= r_wr_sel + 2'(w_wr_last);
            end
            if (w_rd_en) begin
                r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + 1'b1;
                r_rd_sel <= r_rd_sel + 2'(w_rd_last);
                r_data   <= w_win;
            end
            r_pix_cnt <= w_pix_next;
            r_valid   <= w_rd_en;
            r_intr    <= w_rd_last;
            if (r_state == IDLE)
                r_state <= (r_pix_cnt >= THREE_LINES) ? READ : IDLE;
            else if (w_rd_last)
                r_state <= (w_pix_next >= THREE_LINES) ? READ : IDLE;
        end
    end

    assign o_pixel_data       = r_data;
    assign o_pixel_data_valid = r_valid;
    assign o_intr             = r_intr;
endmodule

// File: tb/tb_sobel_line_window.sv
// tb_sobel_line_window: scoreboard bench for sobel_line_window at IMG_WIDTH=8.
// Honours SOBEL_BORDER_ZERO_EN the same way as the design for expected right-edge columns.
module tb_sobel_line_window;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pix = 8'h00;
    logic        pix_valid = 1'b0;
    logic [71:0] o_data;
    logic        o_valid;
    logic        o_intr;

    int n_tests = 0;
    int n_fail = 0;
    int n_intr = 0;
    int g_line = 0;
    logic [71:0] exp_q [$];
    logic [71:0] q_head;

    sobel_line_window #(.IMG_WIDTH(W), .CNT_W(12)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_pixel_data(pix),
        .i_pixel_data_valid(pix_valid),
        .o_pixel_data(o_data),
        .o_pixel_data_valid(o_valid),
        .o_intr(o_intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input logic [7:0] seed, input int top, input int c);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 3; j++) begin
                int a;
                logic [7:0] b;
                a = c + j;
`ifdef SOBEL_BORDER_ZERO_EN
                b = (a >= W) ? 8'h00 : 8'(int'(seed) + (top + r) * 16 + a);
`else
                if (a > W - 1) a = W - 1;
                b = 8'(int'(seed) + (top + r) * 16 + a);
`endif
                w[(r*3+j)*8 +: 8] = b;
            end
        end
        return w;
    endfunction

    always @(negedge clk) begin
        if (o_intr) n_intr++;
        if (o_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_win", o_data, 72'h0);
            end else begin
                q_head = exp_q.pop_front();
                check("win", o_data, q_head);
            end
        end
    end

    task automatic send_line(input logic [7:0] seed);
        for (int c = 0; c < W; c++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix = 8'(int'(seed) + g_line * 16 + c);
        end
        if (g_line >= 2)
            for (int c = 0; c < W; c++) exp_q.push_back(exp_win(seed, g_line - 2, c));
        g_line++;
    endtask

    task automatic idle_in();
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        pix_valid = 1'b0;
        repeat (n) @(negedge clk);
        exp_q.delete();
        g_line = 0;
        rst_n = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain", 72'(exp_q.size()), 72'h0);
    endtask

    initial begin
        int base;
        int run;
        int seen;
        // reset with valid pixels driven
        pix_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pix = 8'(8'hA0 + i);
            @(negedge clk);
            check("rst_data", o_data, 72'h0);
            check("rst_valid", 72'(o_valid), 72'h0);
            check("rst_intr", 72'(o_intr), 72'h0);
        end
        pix_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // fill three lines, then latency and right-edge checks
        for (int l = 0; l < 3; l++) send_line(8'h00);
        idle_in();
        check("lat_e0", 72'(o_valid), 72'h0);
        @(negedge clk);
        check("lat_e1", 72'(o_valid), 72'h0);
        @(negedge clk);
        check("first_valid", 72'(o_valid), 72'h1);
        check("first_win", o_data, 72'h22_21_20_12_11_10_02_01_00);
        check("first_intr", 72'(o_intr), 72'h0);
        repeat (7) @(negedge clk);
        check("last_valid", 72'(o_valid), 72'h1);
`ifdef SOBEL_BORDER_ZERO_EN
        check("edge_win", o_data, 72'h00_00_27_00_00_17_00_00_07);
`else
        check("edge_win", o_data, 72'h27_27_27_17_17_17_07_07_07);
`endif
        check("edge_intr", 72'(o_intr), 72'h1);
        @(negedge clk);
        check("after_valid", 72'(o_valid), 72'h0);
        check("after_intr", 72'(o_intr), 72'h0);

        // stall: nothing more until another line arrives
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        check("stall_quiet", 72'(seen), 72'h0);
        check("stall_intr", 72'(n_intr), 72'h1);
        send_line(8'h00);
        idle_in();
        wait_drain();
        check("stall_intr2", 72'(n_intr), 72'h2);

        // continuous six lines, four back-to-back window lines
        do_reset(2);
        base = n_intr;
        run = 0;
        fork
            begin
                for (int l = 0; l < 6; l++) send_line(8'h40);
                idle_in();
            end
            begin
                for (int i = 0; i < 200 && !o_valid; i++) @(negedge clk);
                while (o_valid && run < 100) begin
                    run++;
                    @(negedge clk);
                end
            end
        join
        check("stream_run", 72'(run), 72'd32);
        wait_drain();
        check("stream_intr", 72'(n_intr - base), 72'h4);

        // reset in the middle of a read
        do_reset(2);
        for (int l = 0; l < 3; l++) send_line(8'h80);
        idle_in();
        seen = 0;
        for (int i = 0; i < 50 && seen < 4; i++) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        check("mid_seen", 72'(seen), 72'h4);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_drop", 72'(o_valid), 72'h0);
        do_reset(2);
        base = n_intr;
        for (int l = 0; l < 3; l++) send_line(8'hC0);
        idle_in();
        wait_drain();
        check("fresh_intr", 72'(n_intr - base), 72'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
